// File: rtl/hyperbus_arbiter_if.sv
// Request/response bus between hyperbus_arbiter (master) and the hyperbus
// leader controller (slave).
interface hyperbus_arbiter_if #(
    parameter int WIDTH       = 8,
    parameter int ADDR_LENGTH = 32,
    parameter int MASK_W      = (2*WIDTH/8)+1
);
    logic [ADDR_LENGTH-1:0] hb_adr;
    logic                   hb_reg_space;
    logic                   hb_wrq;
    logic                   hb_rrq;
    logic [2*WIDTH-1:0]     hb_wdat;
    logic [MASK_W-1:0]      hb_mask;
    logic                   hb_ready;
    logic                   hb_valid;
    logic [2*WIDTH-1:0]     hb_rdat;

    modport master (
        output hb_adr, hb_reg_space, hb_wrq, hb_rrq, hb_wdat, hb_mask,
        input  hb_ready, hb_valid, hb_rdat
    );

    modport slave (
        input  hb_adr, hb_reg_space, hb_wrq, hb_rrq, hb_wdat, hb_mask,
        output hb_ready, hb_valid, hb_rdat
    );
endinterface

// File: rtl/hyperbus_arbiter.sv
// Two-port round-robin arbiter and burst sequencer in front of the hyperbus
// leader controller: grants one request, counts beats, aborts stalled reads.
module hyperbus_arbiter #(
    parameter int WIDTH       = 8,
    parameter int ADDR_LENGTH = 32,
    parameter int LEN_W       = 8,
    parameter int MASK_W      = (2*WIDTH/8)+1,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req_0,
    input  logic                   req_1,
    input  logic                   we_0,
    input  logic                   we_1,
    input  logic                   reg_space_0,
    input  logic                   reg_space_1,
    input  logic [ADDR_LENGTH-1:0] adr_0,
    input  logic [ADDR_LENGTH-1:0] adr_1,
    input  logic [LEN_W-1:0]       len_0,
    input  logic [LEN_W-1:0]       len_1,
    input  logic [2*WIDTH-1:0]     wdat_0,
    input  logic [2*WIDTH-1:0]     wdat_1,
    input  logic [MASK_W-1:0]      mask_0,
    input  logic [MASK_W-1:0]      mask_1,

    output logic                   wack_0,
    output logic                   wack_1,
    output logic [2*WIDTH-1:0]     rdat,
    output logic                   rvalid_0,
    output logic                   rvalid_1,
    output logic                   done_0,
    output logic                   done_1,
    output logic                   err_0,
    output logic                   err_1,

    hyperbus_arbiter_if.master     hb
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_W-1:0]       rem_q, rem_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [GAP_W-1:0]       gcnt_q, gcnt_d;
    logic                   last_q, last_d;
    logic                   gnt_q, gnt_d;
    logic                   err_q, err_d;
    logic [ADDR_LENGTH-1:0] adr_q, adr_d;
    logic                   reg_space_q, reg_space_d;
    logic                   wrq_q, wrq_d;
    logic                   rrq_q, rrq_d;

    logic                   sel_port;
    logic                   sel_we;
    logic [LEN_W-1:0]       sel_len;
    logic                   write_beat;
    logic                   read_beat;
    logic                   tmo_expire;
    logic                   data_phase;
    logic                   done_pulse;

    // On a tie the port that did not win last time goes next.
    assign sel_port = (req_0 && req_1) ? ~last_q : req_1;
    assign sel_we   = sel_port ? we_1  : we_0;
    assign sel_len  = sel_port ? len_1 : len_0;

    assign write_beat = (state_q == S_WRITE) && hb.hb_ready && (rem_q != '0);
    assign read_beat  = (state_q == S_READ)  && hb.hb_valid && (rem_q != '0);
    assign tmo_expire = (int'(tmo_q) + 1) >= (TIMEOUT - 1);

    // NOTE: every next-state signal gets its hold value before the case so no
    // path through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        tmo_d       = tmo_q;
        gcnt_d      = gcnt_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        err_d       = err_q;
        adr_d       = adr_q;
        reg_space_d = reg_space_q;

        case (state_q)
            S_IDLE: begin
                if (req_0 || req_1) begin
                    gnt_d       = sel_port;
                    last_d      = sel_port;
                    adr_d       = sel_port ? adr_1 : adr_0;
                    reg_space_d = sel_port ? reg_space_1 : reg_space_0;
                    rem_d       = (sel_len == '0) ? LEN_W'(1) : sel_len;
                    tmo_d       = '0;
                    err_d       = 1'b0;
                    state_d     = sel_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (write_beat) begin
                    rem_d = rem_q - LEN_W'(1);
                end
                if (rem_d == '0) begin
                    state_d = S_GAP;
                    gcnt_d  = '0;
                end
            end
            S_READ: begin
                if (read_beat) begin
                    rem_d = rem_q - LEN_W'(1);
                    tmo_d = '0;
                    if (rem_d == '0) begin
                        state_d = S_GAP;
                        gcnt_d  = '0;
                    end
                end else if (rem_q == '0) begin
                    state_d = S_GAP;
                    gcnt_d  = '0;
                end else if (tmo_expire) begin
                    // A beat in the expiry cycle wins above; only a true stall aborts.
                    state_d = S_GAP;
                    gcnt_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        wrq_d = (state_d == S_WRITE);
        rrq_d = (state_d == S_READ);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            tmo_q       <= '0;
            gcnt_q      <= '0;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            err_q       <= 1'b0;
            adr_q       <= '0;
            reg_space_q <= 1'b0;
            wrq_q       <= 1'b0;
            rrq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            tmo_q       <= tmo_d;
            gcnt_q      <= gcnt_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            err_q       <= err_d;
            adr_q       <= adr_d;
            reg_space_q <= reg_space_d;
            wrq_q       <= wrq_d;
            rrq_q       <= rrq_d;
        end
    end

    // Combinational strobes are held quiet during any reset cycle.
    assign data_phase = !rst && (state_q == S_WRITE) && (rem_q != '0);
    assign done_pulse = !rst && (state_q == S_GAP) && (gcnt_q == '0);

    assign hb.hb_adr       = adr_q;
    assign hb.hb_reg_space = reg_space_q;
    assign hb.hb_wrq       = wrq_q;
    assign hb.hb_rrq       = rrq_q;
    assign hb.hb_wdat      = data_phase ? (gnt_q ? wdat_1 : wdat_0) : '0;
    assign hb.hb_mask      = data_phase ? (gnt_q ? mask_1 : mask_0) : '1;

    assign wack_0   = !rst && write_beat && !gnt_q;
    assign wack_1   = !rst && write_beat &&  gnt_q;
    assign rvalid_0 = !rst && read_beat  && !gnt_q;
    assign rvalid_1 = !rst && read_beat  &&  gnt_q;
    assign rdat     = hb.hb_rdat;

    assign done_0 = done_pulse && !gnt_q;
    assign done_1 = done_pulse &&  gnt_q;
    assign err_0  = done_pulse && !gnt_q && err_q;
    assign err_1  = done_pulse &&  gnt_q && err_q;

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Directed bench for hyperbus_arbiter: a cycle table for the basic write plus
// hand-written sequences for read, round-robin, timeout, reset and len=0.
module tb_hyperbus_arbiter;

    localparam int WIDTH       = 8;
    localparam int ADDR_LENGTH = 32;
    localparam int LEN_W       = 8;
    localparam int MASK_W      = 3;
    localparam int GAP_CYCLES  = 2;
    localparam int TIMEOUT     = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   req_0, req_1, we_0, we_1, reg_space_0, reg_space_1;
    logic [ADDR_LENGTH-1:0] adr_0, adr_1;
    logic [LEN_W-1:0]       len_0, len_1;
    logic [2*WIDTH-1:0]     wdat_0, wdat_1;
    logic [MASK_W-1:0]      mask_0, mask_1;
    logic                   wack_0, wack_1, rvalid_0, rvalid_1;
    logic                   done_0, done_1, err_0, err_1;
    logic [2*WIDTH-1:0]     rdat;

    hyperbus_arbiter_if #(.WIDTH(WIDTH), .ADDR_LENGTH(ADDR_LENGTH), .MASK_W(MASK_W)) hb_bus ();

    hyperbus_arbiter #(
        .WIDTH(WIDTH), .ADDR_LENGTH(ADDR_LENGTH), .LEN_W(LEN_W), .MASK_W(MASK_W),
        .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
        .reg_space_0(reg_space_0), .reg_space_1(reg_space_1),
        .adr_0(adr_0), .adr_1(adr_1), .len_0(len_0), .len_1(len_1),
        .wdat_0(wdat_0), .wdat_1(wdat_1), .mask_0(mask_0), .mask_1(mask_1),
        .wack_0(wack_0), .wack_1(wack_1), .rdat(rdat),
        .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .done_0(done_0), .done_1(done_1), .err_0(err_0), .err_1(err_1),
        .hb(hb_bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        req;
        logic        ready;
        logic [15:0] wdat;
        logic        exp_wrq;
        logic        exp_wack;
        logic        exp_done;
        logic [2:0]  exp_mask;
        logic [15:0] exp_wdat;
    } wvec_t;

    wvec_t wtab[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_timeout(input bit late_beat);
        int n_done;
        n_done = 0;
        req_0 = 1'b1; we_0 = 1'b0; len_0 = 8'd2; adr_0 = 32'h200;
        hb_bus.hb_ready = 1'b0;
        for (int c = 0; c <= 68; c++) begin
            hb_bus.hb_valid = (c == 2) || (late_beat && c == 65);
            hb_bus.hb_rdat  = 16'h5A5A;
            if (c == 67) req_0 = 1'b0;
            @(negedge clk);
            if (done_0) n_done++;
            if (c == 2 || c == 65)
                check($sformatf("tmo%0d_rvalid_c%0d", late_beat, c), rvalid_0, (c == 2) || late_beat);
            if (c == 65) check($sformatf("tmo%0d_rrq_c65", late_beat), hb_bus.hb_rrq, 1);
            if (c == 66) begin
                check($sformatf("tmo%0d_done", late_beat), done_0, 1);
                check($sformatf("tmo%0d_err", late_beat), err_0, !late_beat);
                check($sformatf("tmo%0d_rrq_c66", late_beat), hb_bus.hb_rrq, 0);
            end
            if (c == 67) check($sformatf("tmo%0d_rrq_c67", late_beat), hb_bus.hb_rrq, 0);
            next_cycle();
        end
        check($sformatf("tmo%0d_done_count", late_beat), n_done, 1);
        hb_bus.hb_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_wack, n_rv, n_done, idle;
        logic order[$];
        logic exp_valid;

        // cycle table for a port-0 write, len=4, hb_ready high from cycle 3
        wtab[0]  = '{1'b1, 1'b0, 16'hA000, 1'b0, 1'b0, 1'b0, 3'h7, 16'h0000};
        wtab[1]  = '{1'b1, 1'b0, 16'hA001, 1'b1, 1'b0, 1'b0, 3'h2, 16'hA001};
        wtab[2]  = '{1'b1, 1'b0, 16'hA002, 1'b1, 1'b0, 1'b0, 3'h2, 16'hA002};
        wtab[3]  = '{1'b1, 1'b1, 16'hA003, 1'b1, 1'b1, 1'b0, 3'h2, 16'hA003};
        wtab[4]  = '{1'b1, 1'b1, 16'hA004, 1'b1, 1'b1, 1'b0, 3'h2, 16'hA004};
        wtab[5]  = '{1'b1, 1'b1, 16'hA005, 1'b1, 1'b1, 1'b0, 3'h2, 16'hA005};
        wtab[6]  = '{1'b1, 1'b1, 16'hA006, 1'b1, 1'b1, 1'b0, 3'h2, 16'hA006};
        wtab[7]  = '{1'b1, 1'b1, 16'hA007, 1'b0, 1'b0, 1'b1, 3'h7, 16'h0000};
        wtab[8]  = '{1'b0, 1'b1, 16'hA008, 1'b0, 1'b0, 1'b0, 3'h7, 16'h0000};
        wtab[9]  = '{1'b0, 1'b1, 16'hA009, 1'b0, 1'b0, 1'b0, 3'h7, 16'h0000};
        wtab[10] = '{1'b0, 1'b0, 16'hA00A, 1'b0, 1'b0, 1'b0, 3'h7, 16'h0000};

        rst = 1'b1;
        req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0; reg_space_0 = 0; reg_space_1 = 0;
        adr_0 = '0; adr_1 = '0; len_0 = '0; len_1 = '0;
        wdat_0 = '0; wdat_1 = '0; mask_0 = 3'b010; mask_1 = 3'b101;
        hb_bus.hb_ready = 0; hb_bus.hb_valid = 0; hb_bus.hb_rdat = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wrq", hb_bus.hb_wrq, 0);
        check("rst_rrq", hb_bus.hb_rrq, 0);
        check("rst_adr", hb_bus.hb_adr, 0);
        check("rst_reg_space", hb_bus.hb_reg_space, 0);
        check("rst_mask", hb_bus.hb_mask, 3'h7);
        check("rst_wdat", hb_bus.hb_wdat, 0);
        check("rst_done", {done_0, done_1, err_0, err_1}, 0);
        check("rst_strobes", {wack_0, wack_1, rvalid_0, rvalid_1}, 0);
        next_cycle();
        rst = 1'b0;

        // port 0 write, len=4
        we_0 = 1'b1; len_0 = 8'd4; adr_0 = 32'h40;
        n_wack = 0;
        for (int i = 0; i < 11; i++) begin
            req_0 = wtab[i].req;
            hb_bus.hb_ready = wtab[i].ready;
            wdat_0 = wtab[i].wdat;
            @(negedge clk);
            if (wack_0) n_wack++;
            check($sformatf("wr_c%0d_wrq", i), hb_bus.hb_wrq, wtab[i].exp_wrq);
            check($sformatf("wr_c%0d_wack", i), wack_0, wtab[i].exp_wack);
            check($sformatf("wr_c%0d_done", i), done_0, wtab[i].exp_done);
            check($sformatf("wr_c%0d_err", i), err_0, 0);
            check($sformatf("wr_c%0d_mask", i), hb_bus.hb_mask, wtab[i].exp_mask);
            check($sformatf("wr_c%0d_wdat", i), hb_bus.hb_wdat, wtab[i].exp_wdat);
            next_cycle();
        end
        check("wr_wack_count", n_wack, 4);

        // port 1 read, len=3, adr=0x100, beats every 5 cycles
        req_1 = 1'b1; we_1 = 1'b0; len_1 = 8'd3; adr_1 = 32'h100; reg_space_1 = 1'b1;
        hb_bus.hb_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            exp_valid = (c == 2) || (c == 7) || (c == 12);
            hb_bus.hb_valid = exp_valid;
            hb_bus.hb_rdat  = exp_valid ? 16'hBEE0 + 16'(c) : 16'h0000;
            if (c == 14) req_1 = 1'b0;
            @(negedge clk);
            check($sformatf("rd_c%0d_rvalid1", c), rvalid_1, exp_valid);
            check($sformatf("rd_c%0d_rvalid0", c), rvalid_0, 0);
            if (exp_valid) check($sformatf("rd_c%0d_rdat", c), rdat, 16'hBEE0 + 16'(c));
            check($sformatf("rd_c%0d_rrq", c), hb_bus.hb_rrq, (c >= 1) && (c <= 12));
            check($sformatf("rd_c%0d_done1", c), done_1, c == 13);
            if (c == 13) begin
                check("rd_err1", err_1, 0);
                check("rd_adr", hb_bus.hb_adr, 32'h100);
                check("rd_reg_space", hb_bus.hb_reg_space, 1);
            end
            next_cycle();
        end
        hb_bus.hb_valid = 1'b0;
        reg_space_1 = 1'b0;

        // both ports requesting from reset, len=1 writes
        rst = 1'b1;
        req_0 = 1'b1; req_1 = 1'b1; we_0 = 1'b1; we_1 = 1'b1; len_0 = 8'd1; len_1 = 8'd1;
        hb_bus.hb_ready = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b0;
        idle = 0;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            if (!hb_bus.hb_wrq && !hb_bus.hb_rrq) idle++;
            if (wack_0 || wack_1) begin
                check($sformatf("rr_c%0d_onehot", c), wack_0 && wack_1, 0);
                if (order.size() > 0)
                    check($sformatf("rr_c%0d_gap", c), idle >= GAP_CYCLES + 1, 1);
                order.push_back(wack_1);
                idle = 0;
            end
            next_cycle();
        end
        req_0 = 1'b0; req_1 = 1'b0;
        check("rr_grant_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++)
            check($sformatf("rr_grant%0d", i), order[i], i % 2);
        repeat (5) next_cycle();

        // read stall timeout, then a beat landing exactly on the expiry cycle
        do_timeout(1'b0);
        do_timeout(1'b1);

        // reset in the middle of a write with rem=2
        req_0 = 1'b1; we_0 = 1'b1; len_0 = 8'd4; wdat_0 = 16'hC0DE;
        hb_bus.hb_ready = 1'b1;
        n_done = 0;
        for (int c = 0; c < 11; c++) begin
            if (c == 3) begin rst = 1'b1; req_0 = 1'b0; end
            if (c == 4) rst = 1'b0;
            if (c == 7) begin req_0 = 1'b1; len_0 = 8'd1; end
            if (c == 10) req_0 = 1'b0;
            @(negedge clk);
            if (c <= 6 && done_0) n_done++;
            if (c == 1 || c == 2) check($sformatf("mr_c%0d_wack", c), wack_0, 1);
            if (c == 3) check("mr_c3_wack", wack_0, 0);
            if (c >= 4 && c <= 6) check($sformatf("mr_c%0d_wrq", c), hb_bus.hb_wrq, 0);
            if (c == 8) begin
                check("mr_c8_wrq", hb_bus.hb_wrq, 1);
                check("mr_c8_wack", wack_0, 1);
            end
            if (c == 9) begin
                check("mr_c9_done", done_0, 1);
                check("mr_c9_err", err_0, 0);
            end
            next_cycle();
        end
        check("mr_no_done_after_rst", n_done, 0);
        hb_bus.hb_ready = 1'b0;

        // len=0 read behaves as a single-word burst
        req_1 = 1'b1; we_1 = 1'b0; len_1 = 8'd0;
        n_rv = 0; n_done = 0;
        for (int c = 0; c < 9; c++) begin
            hb_bus.hb_valid = (c >= 1);
            hb_bus.hb_rdat  = 16'h1234;
            if (c == 3) req_1 = 1'b0;
            @(negedge clk);
            if (rvalid_1) n_rv++;
            if (done_1) n_done++;
            check($sformatf("l0_c%0d_rvalid", c), rvalid_1, c == 1);
            next_cycle();
        end
        hb_bus.hb_valid = 1'b0;
        check("l0_rvalid_count", n_rv, 1);
        check("l0_done_count", n_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
